inst_mem_ctl: RTL
=================

# inst_mem_ctl

Parametrised instruction memory for the core's fetch stage. It holds a block-RAM program store that is initialised after reset and can be reloaded at run time through a word-stream load port. Fetch is served through a request/stall handshake with one-cycle registered read latency and fault reporting.

## Interface
- `DEPTH`, 64: words of storage; power of two, ≥ 32.
- `DATA_W`, 32: instruction width in bits.
- `ADDR_W`, 32: byte-address width of `fetch_addr`.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `fetch_req` in 1: fetch request for `fetch_addr` this cycle.
- `fetch_addr` in ADDR_W: byte address.
- `fetch_stall` in 1: downstream stall; hold output registers.
- `fetch_ready` out 1: request accepted when `fetch_req && fetch_ready`.
- `inst` out DATA_W: fetched instruction.
- `inst_valid` out 1: `inst` corresponds to an accepted request.
- `inst_fault` out 1: accepted request was misaligned or out of range.
- `load_start` in 1: one-cycle pulse; enter LOAD from RUN.
- `load_valid` in 1, `load_data` in DATA_W, `load_last` in 1: load stream.
- `load_ready` out 1: load word accepted when `load_valid && load_ready`.
- `busy` out 1: state is not RUN.

## Operation
- States: INIT, LOAD, RUN. Reset forces INIT and clears `init_ptr` and `load_ptr`.
- INIT: one write per cycle to `mem[init_ptr]`, `init_ptr` 0..DEPTH-1. Data is the boot word (see Configuration) or zero. After the write at DEPTH-1, go to RUN.
- RUN: `fetch_ready = !fetch_stall`. An accepted request with a legal address latches `mem[fetch_addr[log2(DEPTH)+1:2]]` into `inst`, with `inst_valid=1` and `inst_fault=0`.
- Illegal address: `fetch_addr[1:0]!=0` or `fetch_addr >= DEPTH*4`. Result is `inst = NOP` (0x00000013), `inst_valid=1`, `inst_fault=1`, and no RAM read.
- No accepted request and no stall: `inst_valid<=0`. `inst` and `inst_fault` hold.
- `fetch_stall=1`: `inst`, `inst_valid` and `inst_fault` all hold. This applies in every state.
- `load_start` in RUN: the fetch in the same cycle is still served. Go to LOAD next cycle with `load_ptr=0`. `load_start` in INIT or LOAD is ignored.
- LOAD: `load_ready=1`, `fetch_ready=0`. Each accepted word writes `mem[load_ptr]`, then `load_ptr++`.
- LOAD exit: `load_last`, or the write to DEPTH-1, returns to RUN next cycle. Words not written keep their previous contents.
- Output reset values: `inst=NOP`, `inst_valid=0`, `inst_fault=0`, `fetch_ready=0`, `load_ready=0`, `busy=1`.
- Reset mid-LOAD or mid-INIT aborts the operation and restarts INIT. Partially loaded contents are overwritten by INIT.

## Timing
- Cycle 0 is the first edge with `reset` low. INIT writes occupy cycles 0..DEPTH-1. `busy=0` and `fetch_ready=1` from cycle DEPTH.
- Fetch latency: request accepted at edge N produces `inst`/`inst_valid` valid after edge N+1. Throughput is one per cycle.
- A load word accepted at edge N is readable by a fetch accepted at edge N+2 or later. The RUN transition guarantees this.
- `fetch_ready` and `load_ready` are registered from the state and never both 1.

## Configuration
- `INST_MEM_BOOTROM_EN` defined:
  - INIT writes `BOOT_IMAGE[i]` for `i < BOOT_LEN` and zero above that.
  - The core can run straight out of reset.
- Not defined:
  - INIT writes zero everywhere and `BOOT_IMAGE` is not referenced.
  - Software must use LOAD before useful execution.
- Timing and state behaviour are identical in both cases.

## Structure
- Package `inst_mem_pkg` holds:
  - state enum `inst_mem_state_t`;
  - `NOP` = 32'h00000013;
  - `BOOT_LEN` = 30;
  - `BOOT_IMAGE[0:29]`, the standard boot/recursion test program. Word 0 = 0x0FC00413, word 29 = 0x00008067.
- Sub-module `inst_mem_bram`:
  - single-port synchronous RAM (`we`, `addr`, `wdata`, `rdata`), inferred as block RAM;
  - no reset on the array.
- Port sharing: INIT/LOAD writes and RUN reads are mutually exclusive by state. The top level muxes the port.
- The top level holds the FSM, the pointers, the address check and the output registers.

## Test plan
- Boot with macro: release reset, wait for `busy=0` (cycle 64). Fetch 0x0 then 0x74. Expect 0x0FC00413 then 0x00008067, with `inst_valid` on consecutive cycles.
- Fault: fetch 0x102, then 0x100. Expect both `inst_fault=1`, `inst=0x00000013`.
- Stall: fetch 0x4. Hold `fetch_stall` for 3 cycles with `fetch_req=1` at 0x8. Expect:
  - `inst=0x0D800113` held valid throughout the stall;
  - `fetch_ready=0` during the stall;
  - 0x0012AA23 after release.
- Load: pulse `load_start`, stream 0xAAAA0001, 0xAAAA0002, 0xAAAA0003 (last). Fetch 0x0, 0x8, 0xC. Expect:
  - 0xAAAA0001 and 0xAAAA0003;
  - word 3 unchanged, 0x00812823.
- Reset mid-load: assert `reset` after two accepted load words. Expect `busy=1` and INIT re-run, after which word 0 = 0x0FC00413.
- Without macro: after INIT, every fetch in range returns 0x00000000 with `inst_fault=0`.

Source files
------------

// File: rtl/inst_mem_ctl_pkg.sv
// Shared types and constants for the instruction memory controller.
// BOOT_IMAGE is only consumed when INST_MEM_BOOTROM_EN is defined.
package inst_mem_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } inst_mem_state_t;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam int          BOOT_LEN = 30;

    // Boot/recursion test program: stack setup, recursive call, return.
    localparam logic [31:0] BOOT_IMAGE [0:BOOT_LEN-1] = '{
        32'h0FC00413, 32'h0D800113, 32'h0012AA23, 32'h00812823,
        32'h00500513, 32'h010000EF, 32'h00A12623, 32'h0000006F,
        32'hFF010113, 32'h00112623, 32'h00812423, 32'h00050413,
        32'h00100793, 32'h0087D863, 32'h00100513, 32'h00C0006F,
        32'hFFF40513, 32'hFDDFF0EF, 32'h00850533, 32'h00C12083,
        32'h00812403, 32'h01010113, 32'h00008067, 32'h00000013,
        32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
        32'h00000013, 32'h00008067
    };

    function automatic logic [31:0] boot_word(input int unsigned idx);
        if (idx < BOOT_LEN) return BOOT_IMAGE[idx];
        return 32'h0;
    endfunction

endpackage

// File: rtl/inst_mem_ctl_if.sv
// Fetch and load-stream signals of the instruction memory controller.
// The controller takes the slave modport; the fetch stage / loader the master.
interface inst_mem_ctl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_stall;
    logic              fetch_ready;
    logic [DATA_W-1:0] inst;
    logic              inst_valid;
    logic              inst_fault;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              busy;

    modport master (
        output fetch_req, fetch_addr, fetch_stall,
        output load_start, load_valid, load_data, load_last,
        input  fetch_ready, inst, inst_valid, inst_fault, load_ready, busy
    );

    modport slave (
        input  fetch_req, fetch_addr, fetch_stall,
        input  load_start, load_valid, load_data, load_last,
        output fetch_ready, inst, inst_valid, inst_fault, load_ready, busy
    );
endinterface

// File: rtl/inst_mem_ctl_bram.sv
// Single-port synchronous RAM with registered read, no reset on the array.
// The read register only updates on en so the fetched word holds between fetches.
module inst_mem_bram #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (en) begin
            r_rdata <= mem[addr];
        end
    end

    assign rdata = r_rdata;
endmodule

// File: rtl/inst_mem_ctl.sv
// Instruction memory controller: INIT fill, run-time LOAD stream, fetch port.
// Define INST_MEM_BOOTROM_EN to fill the store with BOOT_IMAGE during INIT.
module inst_mem_ctl
    import inst_mem_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    inst_mem_ctl_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    inst_mem_state_t   r_state;
    logic [AW-1:0]     r_init_ptr;
    logic [AW-1:0]     r_load_ptr;
    logic              r_inst_valid;
    logic              r_inst_fault;
    logic              r_use_nop;

    logic              w_accept;
    logic              w_illegal;
    logic              w_load_acc;
    logic              w_we;
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_init_data;
    logic [DATA_W-1:0] w_rdata;

    assign bus.fetch_ready = (r_state == ST_RUN) && !bus.fetch_stall;
    assign bus.load_ready  = (r_state == ST_LOAD);
    assign bus.busy        = (r_state != ST_RUN);

    assign w_accept   = bus.fetch_req && bus.fetch_ready;
    assign w_illegal  = (bus.fetch_addr[1:0] != 2'b00) ||
                        (bus.fetch_addr >= ADDR_W'(DEPTH * 4));
    assign w_load_acc = bus.load_valid && (r_state == ST_LOAD);

`ifdef INST_MEM_BOOTROM_EN
    assign w_init_data = DATA_W'(boot_word(32'(r_init_ptr)));
`else
    assign w_init_data = '0;
`endif

    // The RAM port is shared: writes in INIT/LOAD, reads only in RUN.
    always_comb begin
        w_we    = 1'b0;
        w_addr  = bus.fetch_addr[AW+1:2];
        w_wdata = w_init_data;
        if (r_state == ST_INIT) begin
            w_we   = 1'b1;
            w_addr = r_init_ptr;
        end else if (r_state == ST_LOAD) begin
            w_we    = w_load_acc;
            w_addr  = r_load_ptr;
            w_wdata = bus.load_data;
        end
    end

    inst_mem_bram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_bram (
        .clk   (clk),
        .we    (w_we),
        .en    (w_accept && !w_illegal),
        .addr  (w_addr),
        .wdata (w_wdata),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_INIT;
            r_init_ptr   <= '0;
            r_load_ptr   <= '0;
            r_inst_valid <= 1'b0;
            r_inst_fault <= 1'b0;
            r_use_nop    <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_init_ptr <= r_init_ptr + 1'b1;
                    if (r_init_ptr == AW'(DEPTH - 1)) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (bus.load_start) begin
                        r_state    <= ST_LOAD;
                        r_load_ptr <= '0;
                    end
                end
                ST_LOAD: begin
                    if (w_load_acc) begin
                        r_load_ptr <= r_load_ptr + 1'b1;
                        if (bus.load_last || r_load_ptr == AW'(DEPTH - 1)) r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_INIT;
            endcase

            // Faulted fetches return NOP without touching the RAM read register.
            if (!bus.fetch_stall) begin
                if (w_accept) begin
                    r_inst_valid <= 1'b1;
                    r_inst_fault <= w_illegal;
                    r_use_nop    <= w_illegal;
                end else begin
                    r_inst_valid <= 1'b0;
                end
            end
        end
    end

    assign bus.inst       = r_use_nop ? DATA_W'(NOP) : w_rdata;
    assign bus.inst_valid = r_inst_valid;
    assign bus.inst_fault = r_inst_fault;
endmodule
